// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic valid/ready pipeline register with optional 2-entry skid buffer
// Replaces fixed stall/flush inter-stage registers; flush squashes every held entry.
module pipe_stage_buf #(
  parameter int                DATA_W   = 32,
  parameter bit                SKID     = 1'b1,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occ       = state;

  // With the skid entry, ready comes straight from state flops so the stall
  // never ripples combinationally back into the upstream stage.
  generate
    if (SKID) begin : g_skid
      assign in_ready = (state != TWO);
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = RST_DATA;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = TWO;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= RST_DATA;
      skid_q <= RST_DATA;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  occ_bound_a: assert property (@(posedge clk) disable iff (rst) occ != 2'd3);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed and scoreboard checks of pipe_stage_buf, SKID=1 and SKID=0
module tb_pipe_stage_buf;

  localparam logic [31:0] RST_V = 32'h5A5A_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0, flush0 = 1'b0;
  logic        in_valid = 1'b0, in_valid0 = 1'b0;
  logic        in_ready, in_ready0;
  logic [31:0] in_data = '0, in_data0 = '0;
  logic        out_valid, out_valid0;
  logic        out_ready = 1'b0, out_ready0 = 1'b0;
  logic [31:0] out_data, out_data0;
  logic [1:0]  occ, occ0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .SKID(1'b1), .RST_DATA(RST_V)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occ(occ)
  );

  pipe_stage_buf #(.DATA_W(32), .SKID(1'b0), .RST_DATA(RST_V)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .occ(occ0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick; tick;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (occ !== 2'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", occ); end
    checks++; if (out_data !== RST_V) begin failures++; $display("FAIL rst_out_data got=%h exp=%h", out_data, RST_V); end
    rst = 1'b0;
    tick;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data0 !== RST_V) begin failures++; $display("FAIL rst_out_data0 got=%h exp=%h", out_data0, RST_V); end
  endtask

  task automatic test_streaming;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'h100 + i;
      tick;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h100 + i) begin failures++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 32'h100 + i); end
      checks++; if (occ !== 2'd1) begin failures++; $display("FAIL stream_occ_%0d got=%0d exp=1", i, occ); end
    end
    in_valid = 1'b0;
    tick;
    checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0d/%b exp=0/0", occ, out_valid); end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick;
    checks++; if (occ !== 2'd1) begin failures++; $display("FAIL stall_occ1 got=%0d exp=1", occ); end
    in_data = 32'hB;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready1 got=%b exp=1", in_ready); end
    tick;
    checks++; if (occ !== 2'd2) begin failures++; $display("FAIL stall_occ2 got=%0d exp=2", occ); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready2 got=%b exp=0", in_ready); end
    checks++; if (out_data !== 32'hA) begin failures++; $display("FAIL stall_head got=%h exp=a", out_data); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    checks++; if (out_data !== 32'hB || occ !== 2'd1) begin failures++; $display("FAIL stall_second got=%h/%0d exp=b/1", out_data, occ); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_back got=%b exp=1", in_ready); end
    tick;
    checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%0d/%b exp=0/0", occ, out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1; tick;
    in_data   = 32'h2; tick;
    checks++; if (occ !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", occ); end
    in_data = 32'hC;
    flush   = 1'b1;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_two got=%0d/%b exp=0/0", occ, out_valid); end
    checks++; if (out_data !== RST_V) begin failures++; $display("FAIL flush_data got=%h exp=%h", out_data, RST_V); end
    in_valid = 1'b1;
    in_data  = 32'h3; tick;
    in_data   = 32'hC;
    flush     = 1'b1;
    out_ready = 1'b1;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (occ !== 2'd0 || out_data !== RST_V) begin failures++; $display("FAIL flush_one got=%0d/%h exp=0/%h", occ, out_data, RST_V); end
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'hD;
    tick;
    in_valid = 1'b0;
    checks++; if (out_data !== 32'hD || occ !== 2'd1) begin failures++; $display("FAIL flush_after got=%h/%0d exp=d/1", out_data, occ); end
    out_ready = 1'b1;
    tick;
    checks++; if (occ !== 2'd0) begin failures++; $display("FAIL flush_drain got=%0d exp=0", occ); end
  endtask

  task automatic test_skid0;
    out_ready0 = 1'b0;
    in_valid0  = 1'b1;
    in_data0   = 32'h50;
    tick;
    checks++; if (occ0 !== 2'd1) begin failures++; $display("FAIL s0_occ got=%0d exp=1", occ0); end
    in_data0 = 32'h99;
    #1;
    checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL s0_stall_ready got=%b exp=0", in_ready0); end
    tick;
    checks++; if (out_data0 !== 32'h50 || occ0 !== 2'd1) begin failures++; $display("FAIL s0_hold got=%h/%0d exp=50/1", out_data0, occ0); end
    out_ready0 = 1'b1;
    in_data0   = 32'h51;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL s0_comb_ready got=%b exp=1", in_ready0); end
    for (int i = 1; i <= 8; i++) begin
      in_data0 = 32'h50 + i;
      tick;
      checks++; if (out_data0 !== 32'h50 + i || occ0 !== 2'd1) begin failures++; $display("FAIL s0_pass_%0d got=%h/%0d exp=%h/1", i, out_data0, occ0, 32'h50 + i); end
    end
    in_valid0 = 1'b0;
    tick;
    checks++; if (occ0 !== 2'd0) begin failures++; $display("FAIL s0_drain got=%0d exp=0", occ0); end
  endtask

  task automatic test_reset_async;
    out_ready  = 1'b0;
    out_ready0 = 1'b0;
    in_valid   = 1'b1;
    in_valid0  = 1'b1;
    in_data    = 32'h71; in_data0 = 32'h81; tick;
    in_data    = 32'h72; tick;
    in_valid   = 1'b0;
    in_valid0  = 1'b0;
    checks++; if (occ !== 2'd2 || occ0 !== 2'd1) begin failures++; $display("FAIL arst_pre got=%0d/%0d exp=2/1", occ, occ0); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || occ !== 2'd0) begin failures++; $display("FAIL arst_now got=%b/%0d exp=0/0", out_valid, occ); end
    checks++; if (out_data !== RST_V || occ0 !== 2'd0) begin failures++; $display("FAIL arst_data got=%h/%0d exp=%h/0", out_data, occ0, RST_V); end
    tick;
    rst = 1'b0;
    tick;
    checks++; if (in_ready !== 1'b1 || out_data !== RST_V) begin failures++; $display("FAIL arst_release got=%b/%h exp=1/%h", in_ready, out_data, RST_V); end
  endtask

  task automatic test_random;
    logic [31:0] q[$];
    logic [31:0] q0[$];
    logic [31:0] last, last0, exp_d, exp_d0;
    logic        fi, fo, fi0, fo0, fl, fl0;
    last  = RST_V;
    last0 = RST_V;
    for (int c = 0; c < 10000; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      in_data    = $urandom;
      in_valid0  = ($urandom_range(0, 3) != 0);
      out_ready0 = ($urandom_range(0, 2) != 0);
      flush0     = ($urandom_range(0, 31) == 0);
      in_data0   = $urandom;
      #1;
      exp_d  = (q.size() > 0) ? q[0] : last;
      exp_d0 = (q0.size() > 0) ? q0[0] : last0;
      checks++; if (occ !== 2'(q.size())) begin failures++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, occ, q.size()); end
      checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, q.size() < 2); end
      checks++; if (out_data !== exp_d) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, exp_d); end
      checks++; if (occ0 !== 2'(q0.size())) begin failures++; $display("FAIL rnd0_occ c=%0d got=%0d exp=%0d", c, occ0, q0.size()); end
      checks++; if (in_ready0 !== (q0.size() == 0 || out_ready0)) begin failures++; $display("FAIL rnd0_ready c=%0d got=%b exp=%b", c, in_ready0, q0.size() == 0 || out_ready0); end
      checks++; if (out_data0 !== exp_d0) begin failures++; $display("FAIL rnd0_data c=%0d got=%h exp=%h", c, out_data0, exp_d0); end
      fi  = in_valid && (q.size() < 2);
      fo  = out_ready && (q.size() > 0);
      fl  = flush;
      fi0 = in_valid0 && (q0.size() == 0 || out_ready0);
      fo0 = out_ready0 && (q0.size() > 0);
      fl0 = flush0;
      if (fo) void'(q.pop_front());
      if (fl) q.delete(); else if (fi) q.push_back(in_data);
      if (fo0) void'(q0.pop_front());
      if (fl0) q0.delete(); else if (fi0) q0.push_back(in_data0);
      if (fl) last = RST_V; else if (q.size() > 0) last = q[0];
      if (fl0) last0 = RST_V; else if (q0.size() > 0) last0 = q0[0];
      tick;
    end
    flush  = 1'b0;
    flush0 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_stall;
    test_flush;
    test_skid0;
    test_reset_async;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
